// File: rtl/core_host_seq.sv
// core_host_seq
//   Host-side sequencer: fetches op codes from an async-read op memory, issues
//   them to the core on op_ready, and streams DATA_LEN input bytes from an
//   async-read data memory after each load op (mode 0). Independently registers
//   and counts the core's results.
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_start, i_num_ops         program start (sampled in IDLE/DONE) and op count
//   o_op_addr, i_op_code       op memory address / combinational read data
//   o_data_addr, i_data        data memory address / combinational read data
//   i_op_ready, o_op_valid,
//   o_op_mode                  op issue handshake toward the core
//   i_in_ready, o_in_valid,
//   o_in_data                  input byte stream toward the core
//   i_out_valid, i_out_data    core result strobe and data
//   o_res_valid, o_res_data    registered copy of the result
//   o_res_cnt                  saturating result count since start
//   o_busy, o_done             sequencer status
module core_host_seq #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned OUTW     = 14,
    parameter int unsigned DATA_LEN = 2048,
    parameter int unsigned OPAW     = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [OPAW-1:0] i_num_ops,
    output logic [OPAW-1:0] o_op_addr,
    input  logic [OPW-1:0]  i_op_code,
    output logic [10:0]     o_data_addr,
    input  logic [DW-1:0]   i_data,
    input  logic            i_op_ready,
    output logic            o_op_valid,
    output logic [OPW-1:0]  o_op_mode,
    input  logic            i_in_ready,
    output logic            o_in_valid,
    output logic [DW-1:0]   o_in_data,
    input  logic            i_out_valid,
    input  logic [OUTW-1:0] i_out_data,
    output logic            o_res_valid,
    output logic [OUTW-1:0] o_res_data,
    output logic [15:0]     o_res_cnt,
    output logic            o_busy,
    output logic            o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [10:0] LAST_BEAT = 11'(DATA_LEN - 1);

    state_t          r_state;
    state_t          w_next;
    logic [OPAW-1:0] r_num_ops;
    logic [OPAW-1:0] r_op_idx;
    logic [OPW-1:0]  r_op_reg;
    logic [10:0]     r_data_idx;
    logic [15:0]     r_res_cnt;
    logic            r_res_valid;
    logic [OUTW-1:0] r_res_data;

    logic w_start_ok;
    logic w_last_issue;
    logic w_last_load;
    logic w_beat;
    logic w_last_beat;

    assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // In ISSUE the index still points at the current op; by LOAD it has
    // already been advanced, so "last op" compares against num_ops itself.
    assign w_last_issue = (r_op_idx == (r_num_ops - OPAW'(1)));
    assign w_last_load  = (r_op_idx == r_num_ops);
    assign w_beat       = (r_state == S_LOAD) && i_in_ready;
    assign w_last_beat  = w_beat && (r_data_idx == LAST_BEAT);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_next = (i_num_ops == '0) ? S_DONE : S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (i_op_ready) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_op_reg == '0)    w_next = S_LOAD;
                else if (w_last_issue) w_next = S_DONE;
                else                   w_next = S_WAIT_RDY;
            end
            S_LOAD: begin
                if (w_last_beat) w_next = w_last_load ? S_DONE : S_WAIT_RDY;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state only, so an async reset clears them at once
    always_comb begin
        o_op_valid = 1'b0;
        o_op_mode  = '0;
        o_in_valid = 1'b0;
        o_in_data  = '0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_WAIT_RDY: o_busy = 1'b1;
            S_ISSUE: begin
                o_busy     = 1'b1;
                o_op_valid = 1'b1;
                o_op_mode  = r_op_reg;
            end
            S_LOAD: begin
                o_busy     = 1'b1;
                o_in_valid = 1'b1;
                o_in_data  = i_data;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Sequencer datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num_ops  <= '0;
            r_op_idx   <= '0;
            r_op_reg   <= '0;
            r_data_idx <= '0;
        end else begin
            if (w_start_ok) begin
                r_num_ops <= i_num_ops;
                r_op_idx  <= '0;
            end
            if ((r_state == S_WAIT_RDY) && i_op_ready) r_op_reg <= i_op_code;
            if (r_state == S_ISSUE) begin
                r_op_idx   <= r_op_idx + OPAW'(1);
                r_data_idx <= '0;
            end
            if (w_last_beat)  r_data_idx <= '0;
            else if (w_beat)  r_data_idx <= r_data_idx + 11'd1;
        end
    end

    // Result path, independent of the sequencer state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_cnt   <= '0;
        end else begin
            r_res_valid <= i_out_valid;
            r_res_data  <= i_out_data;
            // A start in the same cycle as a result wins: that result is dropped
            if (w_start_ok)                           r_res_cnt <= '0;
            else if (i_out_valid && (r_res_cnt != '1)) r_res_cnt <= r_res_cnt + 16'd1;
        end
    end

    assign o_op_addr   = r_op_idx;
    assign o_data_addr = r_data_idx;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_cnt   = r_res_cnt;

endmodule

// File: tb/tb_core_host_seq.sv
module tb_core_host_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  num_ops = '0;
    logic [9:0]  o_op_addr;
    logic [3:0]  op_code;
    logic [10:0] o_data_addr;
    logic [7:0]  data;
    logic        op_ready = 1'b0;
    logic        o_op_valid;
    logic [3:0]  o_op_mode;
    logic        in_ready = 1'b0;
    logic        o_in_valid;
    logic [7:0]  o_in_data;
    logic        out_valid = 1'b0;
    logic [13:0] out_data = '0;
    logic        o_res_valid;
    logic [13:0] o_res_data;
    logic [15:0] o_res_cnt;
    logic        o_busy;
    logic        o_done;

    logic [3:0]  op_mem   [1024];
    logic [7:0]  data_mem [2048];

    typedef struct {
        int          due;
        logic [13:0] d;
    } res_t;

    logic [3:0]  exp_op   [$];
    logic [18:0] exp_beat [$];
    res_t        exp_res  [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beat_cnt = 0;
    int in_mode  = 0;   // 0 low, 1 high, 2 toggle
    int rdy_mode = 0;   // 0 low, 1 high, 2 pulse every 4 cycles
    logic prev_opv = 1'b0;

    assign op_code = op_mem[o_op_addr];
    assign data    = data_mem[o_data_addr];

    core_host_seq #(.OPW(4), .DW(8), .OUTW(14), .DATA_LEN(2048), .OPAW(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_ops(num_ops),
        .o_op_addr(o_op_addr), .i_op_code(op_code),
        .o_data_addr(o_data_addr), .i_data(data),
        .i_op_ready(op_ready), .o_op_valid(o_op_valid), .o_op_mode(o_op_mode),
        .i_in_ready(in_ready), .o_in_valid(o_in_valid), .o_in_data(o_in_data),
        .i_out_valid(out_valid), .i_out_data(out_data),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_cnt(o_res_cnt),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Ready generators: the only drivers of in_ready / op_ready
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            k++;
            case (in_mode)
                0:       in_ready = 1'b0;
                1:       in_ready = 1'b1;
                default: in_ready = ~in_ready;
            endcase
            case (rdy_mode)
                0:       op_ready = 1'b0;
                1:       op_ready = 1'b1;
                default: op_ready = ((k % 4) == 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        if (rst) begin
            prev_opv = 1'b0;
        end else begin
            if (o_op_valid) begin
                chk("op_valid_back_to_back", 32'(prev_opv), 32'd0);
                if (exp_op.size() == 0) chk("op_unexpected", 32'(o_op_mode), 32'hFFFF);
                else chk("op_mode", 32'(o_op_mode), 32'(exp_op.pop_front()));
            end else if (o_op_mode != '0) begin
                chk("op_mode_idle_zero", 32'(o_op_mode), 32'd0);
            end
            prev_opv = o_op_valid;

            if (o_in_valid && in_ready) begin
                beat_cnt++;
                if (exp_beat.size() == 0) chk("beat_unexpected", 32'(o_data_addr), 32'hFFFF);
                else begin
                    logic [18:0] e;
                    e = exp_beat.pop_front();
                    chk("beat_addr", 32'(o_data_addr), 32'(e[18:8]));
                    chk("beat_data", 32'(o_in_data), 32'(e[7:0]));
                end
            end else if (!o_in_valid && (o_in_data != '0)) begin
                chk("in_data_idle_zero", 32'(o_in_data), 32'd0);
            end

            if (o_res_valid) begin
                if (exp_res.size() == 0) chk("res_unexpected", 32'(o_res_data), 32'hFFFF);
                else begin
                    res_t r;
                    r = exp_res.pop_front();
                    chk("res_data", 32'(o_res_data), 32'(r.d));
                    chk("res_latency", 32'(cyc), 32'(r.due));
                end
            end
        end
    end

    task automatic do_start(input logic [9:0] n);
        @(posedge clk); #1;
        num_ops = n;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !o_done; i++) @(negedge clk);
        chk("done_reached", 32'(o_done), 32'd1);
    endtask

    task automatic push_load();
        for (int i = 0; i < 2048; i++) exp_beat.push_back({11'(i), data_mem[i]});
    endtask

    task automatic pulse_res(input logic [13:0] d, input int gap);
        @(posedge clk); #1;
        out_valid = 1'b1;
        out_data  = d;
        exp_res.push_back('{due: cyc + 1, d: d});
        @(posedge clk); #1;
        out_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) op_mem[i] = 4'hF;
        for (int i = 0; i < 2048; i++) data_mem[i] = 8'((i * 37 + 11) ^ (i >> 5));

        // Reset state
        #2;
        chk("rst_op_valid", 32'(o_op_valid), 32'd0);
        chk("rst_in_valid", 32'(o_in_valid), 32'd0);
        chk("rst_busy_done", 32'({o_busy, o_done}), 32'd0);
        chk("rst_addrs", 32'({o_op_addr, o_data_addr}), 32'd0);
        chk("rst_res", 32'({o_res_valid, o_res_cnt}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // num_ops=0: DONE straight after the start edge, no op issued
        do_start(10'd0);
        chk("zero_ops_done", 32'(o_done), 32'd1);
        chk("zero_ops_busy", 32'(o_busy), 32'd0);
        repeat (3) @(posedge clk);

        // Two non-load ops, op_ready pulsed every 4 cycles
        op_mem[0] = 4'd3;
        op_mem[1] = 4'd5;
        exp_op.push_back(4'd3);
        exp_op.push_back(4'd5);
        rdy_mode = 2;
        do_start(10'd2);
        wait_done(100);
        chk("t1_ops_left", 32'(exp_op.size()), 32'd0);
        chk("t1_op_addr", 32'(o_op_addr), 32'd2);

        // One load op, in_ready constantly high
        op_mem[0] = 4'd0;
        rdy_mode = 1;
        in_mode  = 1;
        beat_cnt = 0;
        exp_op.push_back(4'd0);
        push_load();
        do_start(10'd1);
        wait_done(2200);
        chk("t2_beats", 32'(beat_cnt), 32'd2048);
        chk("t2_beats_left", 32'(exp_beat.size()), 32'd0);
        @(negedge clk);
        chk("t2_in_valid_after", 32'(o_in_valid), 32'd0);

        // Same load with in_ready toggling
        in_mode  = 2;
        beat_cnt = 0;
        exp_op.push_back(4'd0);
        push_load();
        do_start(10'd1);
        wait_done(4300);
        chk("t3_beats", 32'(beat_cnt), 32'd2048);
        chk("t3_beats_left", 32'(exp_beat.size()), 32'd0);

        // Results while in DONE
        for (int i = 0; i < 5; i++) pulse_res(14'(100 + i), i % 2);
        @(posedge clk); #1;
        chk("t4_res_cnt", 32'(o_res_cnt), 32'd5);
        chk("t4_res_left", 32'(exp_res.size()), 32'd0);
        // Start coinciding with a result: counter clears, result not counted
        @(posedge clk); #1;
        num_ops   = 10'd0;
        start     = 1'b1;
        out_valid = 1'b1;
        out_data  = 14'd200;
        exp_res.push_back('{due: cyc + 1, d: 14'd200});
        @(posedge clk); #1;
        start     = 1'b0;
        out_valid = 1'b0;
        chk("t4_cnt_cleared", 32'(o_res_cnt), 32'd0);
        pulse_res(14'd201, 1);
        chk("t4_cnt_after", 32'(o_res_cnt), 32'd1);

        // Start while busy is ignored
        op_mem[0] = 4'd3;
        rdy_mode  = 0;
        do_start(10'd1);
        repeat (3) @(posedge clk);
        #1;
        do_start(10'd5);
        chk("t6_busy_hold", 32'(o_busy), 32'd1);
        chk("t6_op_addr_hold", 32'(o_op_addr), 32'd0);
        exp_op.push_back(4'd3);
        rdy_mode = 1;
        wait_done(50);
        chk("t6_num_ops_kept", 32'(o_op_addr), 32'd1);
        chk("t6_ops_left", 32'(exp_op.size()), 32'd0);

        // Reset in the middle of a load, then restart
        op_mem[0] = 4'd0;
        in_mode   = 1;
        exp_op.push_back(4'd0);
        push_load();
        do_start(10'd1);
        for (int i = 0; i < 3000 && o_data_addr != 11'd1000; i++) @(negedge clk);
        chk("t5_reach_1000", 32'(o_data_addr), 32'd1000);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_in_valid", 32'(o_in_valid), 32'd0);
        chk("t5_rst_in_data", 32'(o_in_data), 32'd0);
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_data_addr", 32'(o_data_addr), 32'd0);
        chk("t5_rst_cnt", 32'(o_res_cnt), 32'd0);
        exp_beat.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        beat_cnt = 0;
        exp_op.push_back(4'd0);
        push_load();
        do_start(10'd1);
        wait_done(2200);
        chk("t5_beats", 32'(beat_cnt), 32'd2048);
        chk("t5_beats_left", 32'(exp_beat.size()), 32'd0);

        chk("final_ops_left", 32'(exp_op.size()), 32'd0);
        chk("final_res_left", 32'(exp_res.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
